// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU interrupt controller: address geometry,
// vector table layout and the controller state encoding.
package mpu_pkg;

  localparam int          PC_WIDTH      = 8;
  localparam logic [7:0]  VECTOR_BASE   = 8'hF0;
  localparam int unsigned VECTOR_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Vector address for a given line index, wrapping within the program space.
  function automatic logic [PC_WIDTH-1:0] vector_addr(input int unsigned idx);
    logic [31:0] sum;
    sum = 32'(VECTOR_BASE) + idx * VECTOR_STRIDE;
    return sum[PC_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Lowest-index-first priority encoder. Purely combinational; produces the
// index of the lowest set request bit and a flag that any bit is set.
module irq_priority_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mpu_interrupt_ctrl.sv
// Single-level vectored interrupt controller for the MPU program sequencer.
// Latches rising edges of the request lines, picks the highest-priority
// enabled line at an instruction boundary, overrides the sequencer with the
// vector address, and restores the saved PC on return-from-interrupt.
module mpu_interrupt_ctrl
  import mpu_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                gie,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_data,
  input  logic                instr_boundary,
  input  logic                rti,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic                force_jmp,
  output logic [PC_WIDTH-1:0] force_addr,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic                in_service,
  output logic [NUM_IRQ-1:0]  pending
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_e          state_reg, state_next;
  logic [NUM_IRQ-1:0]  irq_d_reg;
  logic [NUM_IRQ-1:0]  pending_reg, pending_next;
  logic [NUM_IRQ-1:0]  mask_reg;
  logic [PC_WIDTH-1:0] saved_pc_reg;
  logic                force_jmp_reg, force_jmp_next;
  logic [PC_WIDTH-1:0] force_addr_reg, force_addr_next;
  logic [NUM_IRQ-1:0]  irq_ack_reg, irq_ack_next;
  logic                in_service_reg, in_service_next;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  eligible;
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_valid;
  logic                accept;
  logic                ret_fire;

  assign rise     = irq & ~irq_d_reg;
  assign eligible = pending_reg & mask_reg;

  irq_priority_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (eligible),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // A new edge on a line wins over the clear caused by accepting that line.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
      assign pending_next[gi] = rise[gi] |
        (pending_reg[gi] & ~(accept && (enc_idx == IDX_W'(gi))));
    end
  endgenerate

  // Edge-detect history, pending latch, mask register and saved return PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_d_reg    <= '0;
      pending_reg  <= '0;
      mask_reg     <= '0;
      saved_pc_reg <= '0;
    end else begin
      irq_d_reg   <= irq;
      pending_reg <= pending_next;
      if (mask_we) begin
        mask_reg <= mask_data;
      end
      if (accept) begin
        saved_pc_reg <= pc_in;
      end
    end
  end

  // State register plus the registered vector-jump outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      force_jmp_reg  <= 1'b0;
      force_addr_reg <= '0;
      irq_ack_reg    <= '0;
      in_service_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      force_jmp_reg  <= force_jmp_next;
      force_addr_reg <= force_addr_next;
      irq_ack_reg    <= irq_ack_next;
      in_service_reg <= in_service_next;
    end
  end

  // Next-state logic: accept in IDLE, one vector cycle in TAKE, wait for rti.
  always_comb begin
    state_next      = state_reg;
    force_jmp_next  = 1'b0;
    force_addr_next = force_addr_reg;
    irq_ack_next    = '0;
    in_service_next = in_service_reg;
    accept          = 1'b0;
    ret_fire        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gie && enc_valid && instr_boundary) begin
          accept          = 1'b1;
          state_next      = TAKE;
          force_jmp_next  = 1'b1;
          force_addr_next = vector_addr(32'(enc_idx));
          irq_ack_next    = NUM_IRQ'(1) << enc_idx;
        end
      end
      TAKE: begin
        state_next      = SERVICE;
        in_service_next = 1'b1;
      end
      SERVICE: begin
        if (rti && instr_boundary) begin
          ret_fire        = 1'b1;
          state_next      = IDLE;
          in_service_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The return jump bypasses the registers so the sequencer reloads the
  // saved PC in the same boundary cycle that decoded the rti.
  assign force_jmp  = force_jmp_reg | ret_fire;
  assign force_addr = ret_fire ? saved_pc_reg : force_addr_reg;
  assign irq_ack    = irq_ack_reg;
  assign in_service = in_service_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_mpu_interrupt_ctrl.sv
// Testbench for mpu_interrupt_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural model of the controller.
module tb_mpu_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq = 4'hF;
  logic       gie = 1'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_data = 4'h0;
  logic       instr_boundary = 1'b0;
  logic       rti = 1'b0;
  logic [7:0] pc_in = 8'h00;
  logic       force_jmp;
  logic [7:0] force_addr;
  logic [3:0] irq_ack;
  logic       in_service;
  logic [3:0] pending;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model: pending set, mask, saved PC, "handler running" flag,
  // and the index whose vector jump is due this cycle (-1 when none).
  logic [3:0] m_pending, m_mask, m_prev_irq;
  logic [7:0] m_saved;
  bit         m_handler;
  int         m_vec_due;

  // Observed outputs of the most recent cycle.
  logic       o_fj, o_ins;
  logic [7:0] o_fa;
  logic [3:0] o_ack, o_pend;

  mpu_interrupt_ctrl #(.NUM_IRQ(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .gie            (gie),
    .mask_we        (mask_we),
    .mask_data      (mask_data),
    .instr_boundary (instr_boundary),
    .rti            (rti),
    .pc_in          (pc_in),
    .force_jmp      (force_jmp),
    .force_addr     (force_addr),
    .irq_ack        (irq_ack),
    .in_service     (in_service),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_pending  = 4'h0;
    m_mask     = 4'h0;
    m_prev_irq = 4'h0;
    m_saved    = 8'h00;
    m_handler  = 1'b0;
    m_vec_due  = -1;
  endtask

  // One clock cycle: entered 1 time unit after a rising edge with inputs set.
  task automatic cycle(input string tag);
    logic       exp_fj;
    logic [7:0] exp_fa;
    logic [3:0] exp_ack;
    logic [3:0] rise;
    int         w;
    #4;
    o_fj   = force_jmp;
    o_fa   = force_addr;
    o_ack  = irq_ack;
    o_ins  = in_service;
    o_pend = pending;

    exp_fj  = 1'b0;
    exp_fa  = 8'h00;
    exp_ack = 4'h0;
    if (m_vec_due >= 0) begin
      exp_fj  = 1'b1;
      exp_fa  = 8'((240 + 4 * m_vec_due) % 256);
      exp_ack = 4'(1 << m_vec_due);
    end else if (m_handler && rti && instr_boundary) begin
      exp_fj = 1'b1;
      exp_fa = m_saved;
    end

    check({tag, "_pending"}, 32'(o_pend), 32'(m_pending));
    check({tag, "_in_service"}, 32'(o_ins), 32'(m_handler));
    check({tag, "_force_jmp"}, 32'(o_fj), 32'(exp_fj));
    check({tag, "_irq_ack"}, 32'(o_ack), 32'(exp_ack));
    if (exp_fj) begin
      check({tag, "_force_addr"}, 32'(o_fa), 32'(exp_fa));
      $display("%0t %s: jump to %02h ack=%b pending=%b", $time, tag, o_fa, o_ack, o_pend);
    end

    rise = irq & ~m_prev_irq;
    m_prev_irq = irq;
    if (!m_handler && m_vec_due < 0 && gie && instr_boundary && (m_pending & m_mask) != 4'h0) begin
      w = lowest_set(m_pending & m_mask);
      m_saved   = pc_in;
      m_pending = m_pending & ~4'(1 << w);
      m_vec_due = w;
    end else if (m_vec_due >= 0) begin
      m_vec_due = -1;
      m_handler = 1'b1;
    end else if (m_handler && rti && instr_boundary) begin
      m_handler = 1'b0;
    end
    m_pending = m_pending | rise;
    if (mask_we) m_mask = mask_data;

    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously, check the cleared outputs at once, then
  // hold for two edges and release.
  task automatic do_reset(input logic [3:0] irq_val, input string tag);
    irq   = irq_val;
    reset = 1'b1;
    #1;
    check({tag, "_rst_pending"}, 32'(pending), 32'(0));
    check({tag, "_rst_force_jmp"}, 32'(force_jmp), 32'(0));
    check({tag, "_rst_in_service"}, 32'(in_service), 32'(0));
    check({tag, "_rst_irq_ack"}, 32'(irq_ack), 32'(0));
    check({tag, "_rst_force_addr"}, 32'(force_addr), 32'(0));
    $display("%0t %s: reset applied", $time, tag);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    @(posedge clk);
    #1;

    // Reset with all lines high; mask stays 0 so the edges only pend.
    gie = 1'b1; instr_boundary = 1'b1; rti = 1'b0; mask_we = 1'b0;
    do_reset(4'hF, "t1");
    repeat (4) cycle("t1");
    check("t1_no_jump", 32'(o_fj), 32'(0));
    check("t1_pend_all", 32'(o_pend), 32'(4'hF));
    do_reset(4'h0, "t1b");

    // Single line, vector and return.
    instr_boundary = 1'b0; mask_we = 1'b1; mask_data = 4'hF;
    cycle("t2_mask");
    mask_we = 1'b0; pc_in = 8'h13; irq = 4'b0100;
    cycle("t2_edge");
    instr_boundary = 1'b1;
    cycle("t2_accept");
    instr_boundary = 1'b0;
    cycle("t2_take");
    check("t2_vec_addr", 32'(o_fa), 32'(8'hF8));
    check("t2_vec_ack", 32'(o_ack), 32'(4'b0100));
    cycle("t2_svc");
    check("t2_svc_in_service", 32'(o_ins), 32'(1));
    rti = 1'b1; instr_boundary = 1'b1;
    cycle("t2_rti");
    check("t2_ret_jmp", 32'(o_fj), 32'(1));
    check("t2_ret_addr", 32'(o_fa), 32'(8'h13));
    rti = 1'b0; instr_boundary = 1'b0;
    cycle("t2_after");
    check("t2_after_in_service", 32'(o_ins), 32'(0));

    // Simultaneous edges on lines 3 and 1.
    irq = 4'b1010;
    cycle("t3_edge");
    instr_boundary = 1'b1;
    cycle("t3_accept");
    instr_boundary = 1'b0;
    cycle("t3_take");
    check("t3_vec1_addr", 32'(o_fa), 32'(8'hF4));
    cycle("t3_svc");
    rti = 1'b1; instr_boundary = 1'b1;
    cycle("t3_rti");
    rti = 1'b0;
    cycle("t3_accept2");
    instr_boundary = 1'b0;
    cycle("t3_take2");
    check("t3_vec3_addr", 32'(o_fa), 32'(8'hFC));
    check("t3_pend_empty", 32'(o_pend), 32'(4'b0000));

    // New edge while in service only pends until the return.
    irq = 4'b1011;
    cycle("t4_edge");
    instr_boundary = 1'b1;
    cycle("t4_svc");
    check("t4_pend0", 32'(o_pend), 32'(4'b0001));
    check("t4_no_nest", 32'(o_fj), 32'(0));
    rti = 1'b1;
    cycle("t4_rti");
    rti = 1'b0;
    cycle("t4_accept");
    instr_boundary = 1'b0;
    cycle("t4_take");
    check("t4_vec0_addr", 32'(o_fa), 32'(8'hF0));
    cycle("t4_svc2");
    rti = 1'b1; instr_boundary = 1'b1;
    cycle("t4_rti2");
    rti = 1'b0; instr_boundary = 1'b0;

    // Re-edge during accept keeps the bit; mask write uses the old mask.
    irq = 4'b0000;
    cycle("t5_low");
    irq = 4'b0100;
    cycle("t5_edge1");
    irq = 4'b0000;
    cycle("t5_low2");
    irq = 4'b0100; instr_boundary = 1'b1; mask_we = 1'b1; mask_data = 4'h0;
    cycle("t5_accept");
    mask_we = 1'b0; instr_boundary = 1'b0;
    cycle("t5_take");
    check("t5_ack2", 32'(o_ack), 32'(4'b0100));
    check("t5_pend2_kept", 32'(o_pend), 32'(4'b0100));
    cycle("t5_svc");
    rti = 1'b1; instr_boundary = 1'b1;
    cycle("t5_rti");
    rti = 1'b0;
    cycle("t5_masked");
    check("t5_masked_no_jmp", 32'(o_fj), 32'(0));

    // Reset in the middle of a handler loses the saved PC.
    instr_boundary = 1'b0; mask_we = 1'b1; mask_data = 4'hF;
    cycle("t6_mask");
    mask_we = 1'b0; pc_in = 8'hA1; instr_boundary = 1'b1;
    cycle("t6_accept");
    instr_boundary = 1'b0;
    cycle("t6_take");
    cycle("t6_svc");
    check("t6_svc_in_service", 32'(o_ins), 32'(1));
    do_reset(irq, "t6");
    rti = 1'b1; instr_boundary = 1'b1;
    cycle("t6_rti");
    check("t6_rti_no_jmp", 32'(o_fj), 32'(0));
    rti = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      irq            = irq ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      gie            = ($urandom_range(0, 9) != 0);
      instr_boundary = 1'($urandom_range(0, 1));
      rti            = ($urandom_range(0, 3) == 0);
      mask_we        = ($urandom_range(0, 15) == 0);
      mask_data      = 4'($urandom_range(0, 15));
      pc_in          = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) begin
        do_reset(irq, "rnd");
      end else begin
        cycle("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
